// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP arbiter slice.
// Holds mode encodings, the mode-to-issue-gap lookup,
// the default DSP base latency and the in-flight tag.
package dsp_pkg;

  localparam logic [1:0] MODE_8   = 2'd0;
  localparam logic [1:0] MODE_16A = 2'd1;
  localparam logic [1:0] MODE_16  = 2'd2;

  localparam int LAT_BASE_DEF = 1;
  localparam int GAP_W        = 3;

  typedef struct packed {
    logic valid;
    logic tag;
  } tag_t;

  // Cycles from one issue to the earliest next issue.
  // Mode 3 is reserved and shares the MODE_16 gap.
  function automatic logic [GAP_W-1:0] mode_gap(
    input logic [1:0] m
  );
    logic [GAP_W-1:0] g;
    case (m)
      MODE_8:   g = 3'd1;
      MODE_16A: g = 3'd2;
      default:  g = 3'd4;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/dsp_rr_arb2.sv
// Two-way round-robin grant logic with ownership lock.
// Ports: req_i requests, en_i arbitration allowed,
// ptr_i favoured requester, lock_i/owner_i MAC lock,
// gnt_o one-hot grant. Purely combinational.
module dsp_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       ptr_i,
  input  logic       lock_i,
  input  logic       owner_i,
  output logic [1:0] gnt_o
);
  import dsp_pkg::*;

  always_comb begin
    gnt_o = '0;
    priority case (1'b1)
      !en_i: gnt_o = '0;
      lock_i: gnt_o[owner_i] = req_i[owner_i];
      req_i[ptr_i]: gnt_o[ptr_i] = 1'b1;
      default: gnt_o[~ptr_i] = req_i[~ptr_i];
    endcase
  end

endmodule

// File: rtl/dsp_arbiter.sv
// Two-requester arbiter and issue scheduler for DSP_top.
// Ports: req_* client beats (slice r = requester r),
// cfg_pipe_stages depth request, start..pipe_stages
// registered DSP command bus, dsp_out DSP result,
// rsp_valid/rsp_data routed result, busy activity flag.
module dsp_arbiter
  import dsp_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int PIPE_STAGE_WIDTH = 2,
  parameter int SHIFT_BITS       = 2,
  parameter int LAT_BASE         = LAT_BASE_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][1:0]            req_mode,
  input  logic [1:0]                 req_mac,
  input  logic [1:0]                 req_last,
  input  logic [1:0][WIDTH-1:0]      req_aa,
  input  logic [1:0][WIDTH-1:0]      req_bb,
  input  logic [1:0][2*WIDTH-1:0]    req_cc,
  input  logic [1:0][SHIFT_BITS-1:0] req_shift_amount,
  input  logic [1:0]                 req_shift_dir,
  input  logic [PIPE_STAGE_WIDTH-1:0] cfg_pipe_stages,
  output logic                       start,
  output logic [1:0]                 mode,
  output logic                       mac,
  output logic [WIDTH-1:0]           aa,
  output logic [WIDTH-1:0]           bb,
  output logic [2*WIDTH-1:0]         cc,
  output logic [SHIFT_BITS-1:0]      shift_amount,
  output logic                       shift_dir,
  output logic [PIPE_STAGE_WIDTH-1:0] pipe_stages,
  input  logic [2*WIDTH-1:0]         dsp_out,
  output logic [1:0]                 rsp_valid,
  output logic [2*WIDTH-1:0]         rsp_data,
  output logic                       busy
);

  localparam int DEPTH =
    LAT_BASE + (1 << PIPE_STAGE_WIDTH) - 1;

  logic [GAP_W-1:0] gap_q, gap_d;
  logic ptr_q, ptr_d;
  logic lock_q, lock_d;
  logic own_q, own_d;
  logic tag_q, tag_d;

  logic                  start_q, start_d;
  logic [1:0]            mode_q, mode_d;
  logic                  mac_q, mac_d;
  logic [WIDTH-1:0]      aa_q, aa_d;
  logic [WIDTH-1:0]      bb_q, bb_d;
  logic [2*WIDTH-1:0]    cc_q, cc_d;
  logic [SHIFT_BITS-1:0] sha_q, sha_d;
  logic                  shd_q, shd_d;

  logic [PIPE_STAGE_WIDTH-1:0] ps_q, ps_d;
  tag_t pipe_q [DEPTH];
  tag_t pipe_d [DEPTH];
  logic [2*WIDTH-1:0] data_q;

  logic [1:0] gnt;
  logic       any_gnt;
  logic       g;
  logic       arb_en;
  tag_t       tap_e;
  int         tap_idx;

  assign arb_en = (gap_q == '0) && !rst;

  dsp_rr_arb2 u_arb (
    .req_i   (req_valid),
    .en_i    (arb_en),
    .ptr_i   (ptr_q),
    .lock_i  (lock_q),
    .owner_i (own_q),
    .gnt_o   (gnt)
  );

  assign any_gnt   = |gnt;
  assign g         = gnt[1];
  assign req_ready = gnt;

  always_comb begin
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    own_d   = own_q;
    tag_d   = tag_q;
    start_d = any_gnt;
    mode_d  = mode_q;
    mac_d   = mac_q;
    aa_d    = aa_q;
    bb_d    = bb_q;
    cc_d    = cc_q;
    sha_d   = sha_q;
    shd_d   = shd_q;
    if (any_gnt) begin
      // Load gap-1: the counter reads 0 on the
      // first cycle a new issue is allowed.
      gap_d  = mode_gap(req_mode[g]) - GAP_W'(1);
      ptr_d  = ~g;
      tag_d  = g;
      mode_d = req_mode[g];
      mac_d  = req_mac[g];
      aa_d   = req_aa[g];
      bb_d   = req_bb[g];
      cc_d   = req_cc[g];
      sha_d  = req_shift_amount[g];
      shd_d  = req_shift_dir[g];
      if (req_mac[g]) begin
        lock_d = ~req_last[g];
        own_d  = g;
      end
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end
  end

  always_comb begin
    tap_idx = LAT_BASE + int'(ps_q) - 1;
    tap_e   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == tap_idx) tap_e = pipe_q[i];
    end
    pipe_d[0] = {start_q, tag_q};
    // Entries past the tap are retired so a later
    // deeper setting cannot replay them.
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
      if (i - 1 == tap_idx) pipe_d[i].valid = 1'b0;
    end
    busy = (gap_q != '0) || start_q;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | pipe_q[i].valid;
    end
  end

  always_comb begin
    ps_d = ps_q;
    if (!busy && !any_gnt) ps_d = cfg_pipe_stages;
  end

  assign rsp_valid = (tap_e.valid && !rst)
                   ? (2'b01 << tap_e.tag) : 2'b00;
  assign rsp_data  = tap_e.valid ? dsp_out : data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q   <= '0;
      ptr_q   <= 1'b0;
      lock_q  <= 1'b0;
      own_q   <= 1'b0;
      tag_q   <= 1'b0;
      start_q <= 1'b0;
      mode_q  <= '0;
      mac_q   <= 1'b0;
      aa_q    <= '0;
      bb_q    <= '0;
      cc_q    <= '0;
      sha_q   <= '0;
      shd_q   <= 1'b0;
      ps_q    <= '0;
      data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      own_q   <= own_d;
      tag_q   <= tag_d;
      start_q <= start_d;
      mode_q  <= mode_d;
      mac_q   <= mac_d;
      aa_q    <= aa_d;
      bb_q    <= bb_d;
      cc_q    <= cc_d;
      sha_q   <= sha_d;
      shd_q   <= shd_d;
      ps_q    <= ps_d;
      data_q  <= rsp_data;
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign start        = start_q;
  assign mode         = mode_q;
  assign mac          = mac_q;
  assign aa           = aa_q;
  assign bb           = bb_q;
  assign cc           = cc_q;
  assign shift_amount = sha_q;
  assign shift_dir    = shd_q;
  assign pipe_stages  = ps_q;

endmodule

// File: doc/dsp_arbiter.md
# dsp_arbiter

Two-requester round-robin arbiter and issue scheduler in front of a single `DSP_top` instance.
- Accepts operation beats from two clients over valid/ready handshakes.
- Drives the DSP `start` strobe at the issue rate allowed by each precision mode.
- Locks ownership for the length of a MAC chain.
- Tracks in-flight operations through the configured pipeline depth and routes each DSP result back to the requester that issued it.

## Interface
Parameters:
- `WIDTH`, 16: DSP operand width; results are 2*WIDTH.
- `PIPE_STAGE_WIDTH`, 2: width of the pipeline-stage configuration.
- `SHIFT_BITS`, 2: barrel-shift amount width.
- `LAT_BASE`, 1: DSP latency from `start` to valid `out` with `pipe_stages`=0.

Ports (requester vectors are index-packed: requester r occupies slice r):
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  beat offered by requester r.
- `req_ready`  out  2  beat accepted when valid&ready.
- `req_mode`  in  2x2  DSP mode per beat.
- `req_mac`  in  2  beat is part of a MAC chain.
- `req_last`  in  2  final beat of a MAC chain; ignored when mac=0.
- `req_aa`, `req_bb`  in  2xWIDTH each  operands.
- `req_cc`  in  2x2*WIDTH  addend.
- `req_shift_amount`  in  2xSHIFT_BITS  output shift amount.
- `req_shift_dir`  in  2  output shift direction.
- `cfg_pipe_stages`  in  PIPE_STAGE_WIDTH  requested pipeline depth.
- `start`, `mode`, `mac`, `aa`, `bb`, `cc`, `shift_amount`, `shift_dir`, `pipe_stages`  out  DSP widths  DSP command bus.
- `dsp_out`  in  2*WIDTH  DSP `out`.
- `rsp_valid`  out  2  one-cycle result strobe per requester.
- `rsp_data`  out  2*WIDTH  result, shared by both requesters.
- `busy`  out  1  issue gap active or any operation in flight.

## Operation
**Reset**
- All outputs 0; `pipe_stages` = 0; round-robin pointer favours requester 0; no owner; tag pipeline cleared.
- Asserting `rst` mid-operation discards all in-flight results; no `rsp_valid` follows.

**Issue gap**
- After each issue, the next issue is blocked for a mode-dependent gap.
- Gap = 1 cycle for mode 0, 2 for mode 1, 4 for mode 2; mode 3 is treated as mode 2.
- Modelled as a down-counter; a new issue is allowed only when it reads 0.

**Arbitration**
- Applies when the gap counter is 0 and there is no owner.
- Grant goes to the valid requester pointed at; if it is idle, the other valid requester wins.
- After a grant, the pointer moves to the other requester.

**MAC lock**
- An accepted beat with mac=1 and last=0 makes its requester owner.
- Only the owner can be granted until it issues a beat with last=1; that beat clears ownership.
- mac=0 beats never take ownership.

**Issue cycle**
- `req_ready[g]`=1 combinationally in the grant cycle.
- Command bus registered: `start`=1 for exactly one cycle, the next cycle, carrying the granted fields.
- Outside issue cycles `start`=0 and `mac` holds its last issued value.

**Pipeline configuration**
- `cfg_pipe_stages` is copied to `pipe_stages` only when `busy`=0 and no grant occurs in that cycle.
- While busy, a changed value waits until the pipeline drains.

**Result tracking**
- Shift register of length `LAT_BASE`+2^PIPE_STAGE_WIDTH-1 holds {valid, tag}; entries are written at the `start` cycle.
- The entry is read at tap `LAT_BASE`+`pipe_stages`-1 after `start`.
- At that tap: `rsp_valid[tag]`=1 and `rsp_data`=`dsp_out` for one cycle. `rsp_data` holds its value otherwise.
- Responses cannot be stalled; requesters must accept them.

## Timing
- Grant to `start`: 1 cycle.
- `start` to `rsp_valid`: `LAT_BASE`+`pipe_stages` cycles.
- Back-to-back throughput: mode 0 one issue every cycle; mode 1 every 2 cycles; mode 2 every 4 cycles.
- Both requesters valid in the same cycle with no owner: pointer decides, and grants alternate.
- MAC owner valid=0 mid-chain: the arbiter idles; the other requester stays blocked.
- `rsp_valid` is never asserted for both bits in one cycle.

## Structure
- Shared package `dsp_pkg` holds:
  - mode encodings (`MODE_8`, `MODE_16A`, `MODE_16`);
  - the function mode to issue-gap;
  - the `LAT_BASE` default;
  - the in-flight tag struct {valid, tag}.
- One natural sub-module, `dsp_rr_arb2`: two-way round-robin with lock input, purely the grant logic.
- Gap counter, tag pipeline and command register live in `dsp_arbiter`.

## Test plan
- **Single issue:** reset, `pipe_stages`=0, requester 0 mode 0, aa=3, bb=5, cc=0 → `start` one cycle after accept; `rsp_valid`=2'b01 with `rsp_data`=15 at `LAT_BASE` cycles later.
- **Round-robin, mode 0:** both requesters continuously valid → grants alternate 0,1,0,1; one `start` per cycle; each response tag matches its issuer.
- **Mode 2 gap:** requester 1 continuously valid, mode 2 → `start` every 4th cycle; `req_ready` low in the 3 gap cycles.
- **MAC lock:** requester 0 sends 4 mac=1 beats (last on the 4th) while requester 1 is valid → requester 1 granted only after the 4th beat; `mac`=1 on all four issues.
- **Depth change:** `cfg_pipe_stages`=3 applied while busy → `pipe_stages` stays old until drain, then 3; following results arrive `LAT_BASE`+3 cycles after `start`.
- **Reset mid-flight:** 3 operations in flight, assert `rst` one cycle → no `rsp_valid` afterwards; all outputs 0; the next grant goes to requester 0.
